// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the Wishbone instruction fetcher.
//   ifetch_state_e  - fetch FSM encoding (IDLE / REQ / DROP)
//   fetch_entry_t   - one instruction buffer entry {instr, pc}
//   WB_SEL_ALL      - byte selects for full-word reads
//   TIMEOUT_LIMIT   - watchdog limit in bus-wait cycles (IFETCH_TIMEOUT_EN builds)
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } ifetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [3:0] WB_SEL_ALL    = 4'hF;
    localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: small circular instruction buffer.
//   clk_i, rst_ni       - clock, async active-low reset
//   push_i / data_i     - write an entry (ignored when full)
//   pop_i               - drop the head entry (ignored when empty)
//   flush_i             - empty the buffer; overrides push and pop
//   data_o              - head entry (combinational)
//   count_o             - current occupancy
module ifetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic [WIDTH-1:0]             data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, wr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign do_push = push_i && !flush_i && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop_i  && !flush_i && (count_q != '0);

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_W'(1);
            if (do_pop)  rd_q <= rd_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/wishbone_ifetch.sv
// wishbone_ifetch: sequential instruction fetcher on a classic Wishbone read bus.
// Keeps one request in flight, buffers fetched words in ifetch_fifo and
// restarts at a new PC on redirect_i.
//   clk_i, rst_ni             - clock, async active-low reset
//   cyc_o, stb_o, sel_o, adr_o - Wishbone master request (word address)
//   dat_i, ack_i              - Wishbone read data / acknowledge
//   redirect_i, redirect_pc_i - flush and restart fetching at redirect_pc_i
//   instr_o, pc_o, valid_o    - buffer head towards the consumer
//   ready_i                   - consumer takes the head when valid_o & ready_i
//   err_o                     - sticky bus timeout flag
// Optional: define IFETCH_TIMEOUT_EN to enable the bus watchdog; otherwise
// err_o is tied low.
module wishbone_ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          ADDR_W     = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic              cyc_o,
    output logic              stb_o,
    output logic [3:0]        sel_o,
    output logic [ADDR_W-1:0] adr_o,
    input  logic [31:0]       dat_i,
    input  logic              ack_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    output logic [31:0]       instr_o,
    output logic [31:0]       pc_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              err_o
);
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);

    ifetch_state_e     state_q, state_d;
    logic [31:0]       pc_q, pc_d;      // address of the outstanding / next fetch
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_after_ack;
    logic [31:0]       redir_pc;
    logic              push, pop, room_now, room_after_ack, hold_bus;
    logic              halted, timeout;
    fetch_entry_t      wr_entry, head;

    assign redir_pc        = redirect_pc_i & ~32'h3;
    assign pop             = valid_o && ready_i;
    assign push            = (state_q == ST_REQ) && ack_i && !redirect_i;
    assign room_now        = count < CNT_W'(FIFO_DEPTH);
    // In REQ occupancy is below FIFO_DEPTH, so count+1 cannot overflow.
    assign count_after_ack = count + CNT_W'(1) - CNT_W'(pop);
    assign room_after_ack  = count_after_ack < CNT_W'(FIFO_DEPTH);
    // Address must not move while a request waits for its ack.
    assign hold_bus        = (state_q != ST_IDLE) && !ack_i;

`ifdef IFETCH_TIMEOUT_EN
    logic       err_q, err_d;
    logic [7:0] wd_q, wd_d;

    // wd_q counts wait cycles already spent; the 255th one trips.
    assign timeout = (state_q != ST_IDLE) && !ack_i && !redirect_i
                     && (wd_q == TIMEOUT_LIMIT - 8'd1);
    assign halted  = err_q;

    always_comb begin
        err_d = err_q;
        wd_d  = wd_q + 8'd1;
        if (redirect_i)                                    err_d = 1'b0;
        else if (timeout)                                  err_d = 1'b1;
        if (state_q == ST_IDLE || ack_i || redirect_i || timeout) wd_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
            wd_q  <= '0;
        end else begin
            err_q <= err_d;
            wd_q  <= wd_d;
        end
    end

    assign err_o = err_q;
`else
    assign timeout = 1'b0;
    assign halted  = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (redirect_i) begin
                    pc_d    = redir_pc;
                    state_d = ST_REQ;
                end else if (!halted && room_now) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect_i) begin
                    pc_d    = redir_pc;
                    state_d = ack_i ? ST_REQ : ST_DROP;
                end else if (ack_i) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = room_after_ack ? ST_REQ : ST_IDLE;
                end
            end
            ST_DROP: begin
                if (redirect_i) begin
                    pc_d    = redir_pc;
                    state_d = ack_i ? ST_REQ : ST_DROP;
                end else if (ack_i) begin
                    state_d = room_now ? ST_REQ : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (timeout) state_d = ST_IDLE;
        adr_d = hold_bus ? adr_q : pc_d[ADDR_W+1:2];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            adr_q   <= RESET_PC[ADDR_W+1:2];
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            adr_q   <= adr_d;
        end
    end

    assign wr_entry = '{instr: dat_i, pc: pc_q};

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (wr_entry),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .data_o  (head),
        .count_o (count)
    );

    assign cyc_o   = (state_q != ST_IDLE);
    assign stb_o   = (state_q != ST_IDLE);
    assign sel_o   = WB_SEL_ALL;
    assign adr_o   = adr_q;
    assign valid_o = (count != '0);
    assign instr_o = head.instr;
    assign pc_o    = head.pc;

endmodule

// File: tb/tb_wishbone_ifetch.sv
module tb_wishbone_ifetch;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // DUT 1: default parameters
    logic        cyc, stb, ack, redirect, valid, err;
    logic        ready = 1'b0;
    logic [3:0]  sel;
    logic [9:0]  adr;
    logic [31:0] dat, redirect_pc, instr, pc;
    // DUT 2: RESET_PC near the address-wrap point
    logic        cyc2, stb2, ack2, valid2, err2;
    logic        redirect2 = 1'b0, ready2 = 1'b1;
    logic [3:0]  sel2;
    logic [9:0]  adr2;
    logic [31:0] dat2, instr2, pc2;
    logic [31:0] redirect_pc2 = 32'h0;

    wishbone_ifetch u_dut (
        .clk_i(clk), .rst_ni(rst_n), .cyc_o(cyc), .stb_o(stb), .sel_o(sel),
        .adr_o(adr), .dat_i(dat), .ack_i(ack), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .instr_o(instr), .pc_o(pc),
        .valid_o(valid), .ready_i(ready), .err_o(err)
    );

    wishbone_ifetch #(.RESET_PC(32'hFFC), .FIFO_DEPTH(2), .ADDR_W(10)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .cyc_o(cyc2), .stb_o(stb2), .sel_o(sel2),
        .adr_o(adr2), .dat_i(dat2), .ack_i(ack2), .redirect_i(redirect2),
        .redirect_pc_i(redirect_pc2), .instr_o(instr2), .pc_o(pc2),
        .valid_o(valid2), .ready_i(ready2), .err_o(err2)
    );

    // ROM: word n reads as A000_0000 + n; slaves ack one cycle after strobe.
    assign dat  = 32'hA000_0000 + {22'd0, adr};
    assign dat2 = 32'hA000_0000 + {22'd0, adr2};

    logic ack_en = 1'b1;
    int   ack_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack <= 1'b0; ack_cnt <= 0; ack2 <= 1'b0;
        end else begin
            ack  <= cyc && stb && !ack && ack_en;
            ack2 <= cyc2 && stb2 && !ack2;
            if (ack && cyc) ack_cnt <= ack_cnt + 1;
        end
    end

    int n_chk = 0, n_bad = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard of expected deliveries
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;
    exp_t exp_q[$];

    task automatic push_run(input logic [31:0] start, input int n);
        exp_t e;
        logic [31:0] p;
        for (int i = 0; i < n; i++) begin
            p     = start + 32'(4 * i);
            e.pc  = p;
            e.ins = 32'hA000_0000 + {22'd0, p[11:2]};
            exp_q.push_back(e);
        end
    endtask

    logic rdy_en = 1'b1;
    int   pop_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        ready = rdy_en && (exp_q.size() > 0);
        if (rst_n && valid && ready) begin
            e = exp_q.pop_front();
            chk("pop_pc", {32'd0, pc}, {32'd0, e.pc});
            chk("pop_instr", {32'd0, instr}, {32'd0, e.ins});
            pop_cnt++;
        end
        if (redirect) begin
            exp_q.delete();
            push_run(redirect_pc & ~32'h3, 64);
        end
    end

    logic [31:0] pc2_seen [2];
    logic [31:0] in2_seen [2];
    int n2 = 0;
    always @(negedge clk) begin
        if (rst_n && valid2 && n2 < 2) begin
            pc2_seen[n2] = pc2;
            in2_seen[n2] = instr2;
            n2++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_cyc", {63'd0, cyc}, 64'd0);
        chk("rst_stb", {63'd0, stb}, 64'd0);
        chk("rst_valid", {63'd0, valid}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        exp_q.delete();
        repeat (2) tick();
        push_run(32'h0, 64);
        rst_n = 1'b1;
    endtask

    int p0, n;
    logic [9:0] a_before;
    logic found;

    initial begin
        redirect = 1'b0;
        redirect_pc = 32'h0;
        #2;
        // Streaming after reset, plus the wrap instance
        do_reset();
        tick();
        chk("first_stb", {63'd0, stb}, 64'd1);
        chk("first_adr", {54'd0, adr}, 64'd0);
        chk("sel", {60'd0, sel}, 64'hF);
        chk("wrap_adr0", {54'd0, adr2}, 64'h3FF);
        tick();
        tick();
        chk("wrap_adr1", {54'd0, adr2}, 64'h000);
        repeat (3) tick();
        p0 = pop_cnt;
        repeat (20) tick();
        chk("beat_rate", 64'(pop_cnt - p0), 64'd10);
        chk("wrap_n", 64'(n2), 64'd2);
        chk("wrap_pc0", {32'd0, pc2_seen[0]}, 64'hFFC);
        chk("wrap_in0", {32'd0, in2_seen[0]}, 64'hA00003FF);
        chk("wrap_pc1", {32'd0, pc2_seen[1]}, 64'h1000);
        chk("wrap_in1", {32'd0, in2_seen[1]}, 64'hA0000000);
        chk("err_low", {63'd0, err}, 64'd0);

        // Consumer stalled: buffer fills, then bus goes quiet
        rdy_en = 1'b0;
        do_reset();
        repeat (20) tick();
        chk("stall_acks", 64'(ack_cnt), 64'd2);
        chk("stall_cyc", {63'd0, cyc}, 64'd0);
        chk("stall_valid", {63'd0, valid}, 64'd1);
        p0 = pop_cnt;
        rdy_en = 1'b1;
        n = 0;
        while (pop_cnt < p0 + 3 && n < 40) begin tick(); n++; end
        chk("resume", {63'd0, pop_cnt >= p0 + 3}, 64'd1);

        // Redirect while a request is stalled on the bus
        ack_en = 1'b0;
        repeat (8) tick();
        chk("pre_redir_stb", {63'd0, stb}, 64'd1);
        a_before = adr;
        redirect_pc = 32'h0000_0102;
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
        chk("drop_adr_hold", {54'd0, adr}, {54'd0, a_before});
        chk("drop_valid", {63'd0, valid}, 64'd0);
        ack_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (stb && adr == 10'h040) found = 1'b1;
        end
        chk("redir_adr", {63'd0, found}, 64'd1);
        p0 = pop_cnt;
        repeat (10) tick();
        chk("redir_flow", {63'd0, pop_cnt > p0}, 64'd1);

        // Redirect on the ack cycle together with a pop
        rdy_en = 1'b0;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (valid && ack) found = 1'b1;
        end
        chk("ack_pop_setup", {63'd0, found}, 64'd1);
        rdy_en = 1'b1;
        redirect_pc = 32'h0000_0200;
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
        chk("flush_valid", {63'd0, valid}, 64'd0);
        chk("flush_adr", {54'd0, adr}, 64'h080);
        p0 = pop_cnt;
        repeat (10) tick();
        chk("flush_flow", {63'd0, pop_cnt > p0}, 64'd1);

`ifdef IFETCH_TIMEOUT_EN
        // Watchdog: slave never acks
        ack_en = 1'b0;
        do_reset();
        n = 0;
        while (!err && n < 400) begin tick(); n++; end
        chk("wd_cycles", 64'(n), 64'd256);
        chk("wd_err", {63'd0, err}, 64'd1);
        chk("wd_cyc", {63'd0, cyc}, 64'd0);
        repeat (5) tick();
        chk("wd_halt", {63'd0, stb}, 64'd0);
        redirect_pc = 32'h0;
        redirect = 1'b1;
        ack_en = 1'b1;
        tick();
        redirect = 1'b0;
        chk("wd_clear", {63'd0, err}, 64'd0);
        chk("wd_restart", {63'd0, stb}, 64'd1);
`endif

        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/wishbone_ifetch.md
WISHBONE_IFETCH -- requirements
Module: wishbone_ifetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, instruction buffer entries (power of two, >=2).
REQ-003 SHALL have parameter ADDR_W, default 10, Wishbone word-address width.
REQ-004 SHALL have ports as follows; one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- cyc_o  out  1  Wishbone cycle.
- stb_o  out  1  Wishbone strobe.
- sel_o  out  4  byte selects, constant 4'hF.
- adr_o  out  ADDR_W  word address, pc[ADDR_W+1:2].
- dat_i  in  32  read data, valid when ack_i=1.
- ack_i  in  1  Wishbone acknowledge.
- redirect_i  in  1  one-cycle request to change the fetch PC.
- redirect_pc_i  in  32  new PC; bits [1:0] ignored.
- instr_o  out  32  FIFO head instruction.
- pc_o  out  32  byte address of instr_o.
- valid_o  out  1  FIFO non-empty.
- ready_i  in  1  consumer accepts head when valid_o&ready_i.
- err_o  out  1  sticky fetch timeout (see Configuration).

Function
REQ-005 SHALL implement FSM IDLE, REQ, DROP: IDLE issues; REQ waits for ack_i with data kept; DROP waits for ack_i with data discarded.
REQ-006 SHALL leave IDLE for REQ only when FIFO occupancy < FIFO_DEPTH; at most one bus request outstanding.
REQ-007 SHALL hold cyc_o=stb_o=1 and adr_o stable in REQ/DROP until ack_i is sampled high.
REQ-008 On ack_i in REQ without redirect_i: SHALL push {dat_i, fetch_pc} and set fetch_pc+=4.
REQ-009 SHALL, on that same edge, keep stb_o high with the new adr_o if the FIFO still has room, otherwise go to IDLE; peak throughput is one word per 2 cycles against a one-cycle-ack slave.
REQ-010 SHALL wrap fetch_pc modulo 2^32; adr_o wraps modulo 2^ADDR_W.
REQ-011 redirect_i SHALL flush the FIFO (valid_o=0 next cycle) and load fetch_pc = {redirect_pc_i[31:2],2'b00}.
REQ-012 Redirect in REQ without ack_i SHALL move to DROP; DROP ack then issues at the new PC.
REQ-013 Redirect coincident with ack_i SHALL discard dat_i; the next request uses the new PC.
REQ-014 Redirect coincident with a pop SHALL flush the FIFO; the pop has no further effect.
REQ-015 Simultaneous push and pop SHALL keep occupancy unchanged.
REQ-016 instr_o/pc_o SHALL show the FIFO head combinationally; these outputs are don't-care when valid_o=0.

Reset
REQ-017 rst_ni low SHALL immediately force cyc_o=0, stb_o=0, valid_o=0, err_o=0, FSM=IDLE, FIFO empty, fetch_pc=RESET_PC.
REQ-018 Reset mid-request SHALL abandon the cycle; any later ack_i SHALL be ignored in IDLE.
REQ-019 First stb_o SHALL assert in the first cycle after rst_ni deasserts.

Configuration
REQ-020 With IFETCH_TIMEOUT_EN defined: 8-bit watchdog counts REQ/DROP cycles without ack_i; at 255 drop cyc_o/stb_o, set err_o=1, go to IDLE, stop issuing until redirect_i, which clears err_o.
REQ-021 Without IFETCH_TIMEOUT_EN: no watchdog logic; err_o tied 0.

Structure
REQ-022 Package ifetch_pkg SHALL hold the FSM state typedef, WB_SEL_ALL=4'hF, and the timeout limit constant.
REQ-023 The FIFO SHALL be a sub-module ifetch_fifo (parameterised depth/width, push/pop/flush, count).

Verification
REQ-024 Reset release, ROM with word n = 32'hA000_0000+n, ready_i=1 -> (pc_o,instr_o) = (0,A0000000), (4,A0000001), (8,A0000002); one valid beat every 2 cycles.
REQ-025 ready_i=0 for 20 cycles -> exactly FIFO_DEPTH=2 acks, then cyc_o=0; raise ready_i -> pc 0,4 popped, fetching resumes at 8.
REQ-026 redirect_i with redirect_pc_i=32'h0000_0102 while stb_o high -> in-flight data dropped, next adr_o=10'h040, next pc_o=32'h100.
REQ-027 redirect_i on the ack_i cycle and a pop at the same time -> valid_o=0 next cycle; no stale instruction delivered.
REQ-028 RESET_PC=32'hFFC, ADDR_W=10 -> adr_o=10'h3FF then 10'h000, pc_o 0xFFC then 0x1000.
REQ-029 With IFETCH_TIMEOUT_EN, ack_i held 0 -> err_o=1 after 255 cycles, cyc_o=0; redirect_i -> err_o=0, fetch restarts.
